// File: rtl/ps2_receptor.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the raw PS/2 lines,
// deframes 11-bit frames, checks odd parity and the stop bit, folds the
// 0xF0 / 0xE0 prefixes into flags, and abandons stalled frames on timeout.
module ps2_receptor #(
  parameter int FILTRO_N    = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_reloj_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       valid_o,
  output logic       break_o,
  output logic       extended_o,
  output logic       error_o,
  output logic       busy_o
);

  localparam int FW = $clog2(FILTRO_N + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATOS, PARIDAD, PARADA} state_t;

  state_t        state, state_next;
  logic          ck_s1, ck_s2, dt_s1, dt_s2;
  logic          filt, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          parity;
  logic [TW-1:0] tout_cnt;
  logic          tout_hit;
  logic          frame_done;
  logic          good;
  logic          brk_pend, ext_pend;

  // Two-flop synchronizers; idle level of both PS/2 lines is high.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ck_s1 <= 1'b1;
      ck_s2 <= 1'b1;
      dt_s1 <= 1'b1;
      dt_s2 <= 1'b1;
    end else begin
      ck_s1 <= ps2_reloj_i;
      ck_s2 <= ck_s1;
      dt_s1 <= ps2_data_i;
      dt_s2 <= dt_s1;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTRO_N consecutive differing samples.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      filt      <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt;
      if (ck_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTRO_N - 1)) begin
        filt     <= ck_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // One-cycle strobe on the filtered 1 -> 0 transition; data is sampled on this cycle.
  assign fall   = filt_prev & ~filt;
  assign busy_o = (state != IDLE);

  // Odd parity across data and parity bit, plus a high stop bit.
  assign good = (^shift ^ parity) & dt_s2;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; timeout wins only when no edge arrives on the same cycle.
  always_comb begin
    state_next = state;
    tout_hit   = 1'b0;
    frame_done = 1'b0;
    if (state != IDLE && !fall && tout_cnt == TW'(TIMEOUT_CYC - 1)) begin
      tout_hit   = 1'b1;
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!dt_s2) state_next = DATOS;
        DATOS:   if (bit_cnt == 3'd7) state_next = PARIDAD;
        PARIDAD: state_next = PARADA;
        PARADA: begin
          state_next = IDLE;
          frame_done = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Inactivity counter: restarts on each edge, runs only while a frame is open.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tout_cnt <= '0;
    end else if (fall || state == IDLE || tout_hit) begin
      tout_cnt <= '0;
    end else begin
      tout_cnt <= tout_cnt + 1'b1;
    end
  end

  // Datapath: shifting, parity capture, prefix tracking and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      parity     <= 1'b0;
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
      code_o     <= 8'h00;
      break_o    <= 1'b0;
      extended_o <= 1'b0;
      valid_o    <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      error_o <= 1'b0;
      if (fall && state == DATOS) begin
        shift   <= {dt_s2, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARIDAD) parity <= dt_s2;
      if (tout_hit || (frame_done && !good)) begin
        error_o  <= 1'b1;
        brk_pend <= 1'b0;
        ext_pend <= 1'b0;
        shift    <= 8'h00;
        bit_cnt  <= 3'd0;
      end else if (frame_done) begin
        shift   <= 8'h00;
        bit_cnt <= 3'd0;
        if (shift == 8'hF0) begin
          brk_pend <= 1'b1;
        end else if (shift == 8'hE0) begin
          ext_pend <= 1'b1;
        end else begin
          code_o     <= shift;
          break_o    <= brk_pend;
          extended_o <= ext_pend;
          valid_o    <= 1'b1;
          brk_pend   <= 1'b0;
          ext_pend   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_receptor.sv
// Scoreboard bench for ps2_receptor: frames are generated bit by bit, the
// expected outcome of each frame is queued when it is sent, and a monitor
// pops and compares on every valid_o / error_o pulse.
module tb_ps2_receptor;

  localparam int HALF = 30;

  typedef struct {
    logic       is_err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] code;
  logic       valid, brk, ext, err, busy;

  exp_t       exp_q[$];
  logic       brk_p = 1'b0;
  logic       ext_p = 1'b0;
  logic [7:0] last_code = 8'h00;
  int         n_checks = 0;
  int         n_pass = 0;

  ps2_receptor dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ps2_reloj_i (ps2_clk),
    .ps2_data_i  (ps2_dat),
    .code_o      (code),
    .valid_o     (valid),
    .break_o     (brk),
    .extended_o  (ext),
    .error_o     (err),
    .busy_o      (busy)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Drive the first nbits bits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop, input int nbits);
    logic [10:0] fr;
    fr = {stop, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk);
      ps2_dat = fr[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_dat = 1'b1;
  endtask

  task automatic push_err();
    exp_t e;
    e = '{1'b1, 8'h00, 1'b0, 1'b0};
    exp_q.push_back(e);
    brk_p = 1'b0;
    ext_p = 1'b0;
  endtask

  task automatic good_frame(input logic [7:0] b);
    exp_t e;
    if (b == 8'hF0) brk_p = 1'b1;
    else if (b == 8'hE0) ext_p = 1'b1;
    else begin
      e = '{1'b0, b, brk_p, ext_p};
      exp_q.push_back(e);
      last_code = b;
      brk_p = 1'b0;
      ext_p = 1'b0;
    end
    send_bits(b, 1'b0, 1'b1, 11);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (valid || err) begin
      exp_t e;
      if (valid && err) check("overlap", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, valid, err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("kind", {31'd0, err}, {31'd0, e.is_err});
        if (!e.is_err && valid) begin
          check("code", {24'd0, code}, {24'd0, e.code});
          check("break", {31'd0, brk}, {31'd0, e.brk});
          check("extended", {31'd0, ext}, {31'd0, e.ext});
          $display("rx code=%02h break=%0b extended=%0b", code, brk, ext);
        end else begin
          $display("rx error pulse");
        end
      end
    end
  end

  initial begin
    // Reset state.
    wait_cyc(5);
    @(negedge clk);
    check("rst_code", {24'd0, code}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_break", {31'd0, brk}, 32'd0);
    check("rst_ext", {31'd0, ext}, 32'd0);
    check("rst_error", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    rst = 1'b1;
    wait_cyc(10);

    // Short low glitch on the clock with data low must not open a frame.
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(20);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    ps2_dat = 1'b1;
    wait_cyc(20);

    // Plain, break, extended and combined prefixes.
    good_frame(8'h1C);
    good_frame(8'hF0);
    good_frame(8'h1C);
    good_frame(8'h1C);
    good_frame(8'hE0);
    good_frame(8'hF0);
    good_frame(8'h75);
    good_frame(8'hE0);
    good_frame(8'h74);

    // Parity error then stop-bit error; code must hold.
    push_err();
    send_bits(8'h1C, 1'b1, 1'b1, 11);
    push_err();
    send_bits(8'h1C, 1'b0, 1'b0, 11);
    wait_cyc(10);
    check("code_hold", {24'd0, code}, {24'd0, last_code});

    // Stalled frame: 5 bits then the clock stays high.
    send_bits(8'h1C, 1'b0, 1'b1, 5);
    wait_cyc(10);
    check("busy_mid", {31'd0, busy}, 32'd1);
    push_err();
    wait_cyc(10100);
    check("busy_after_tout", {31'd0, busy}, 32'd0);
    good_frame(8'h1C);

    // Reset in the middle of an F0 frame discards it entirely.
    send_bits(8'hF0, 1'b0, 1'b1, 5);
    @(posedge clk);
    rst = 1'b0;
    wait_cyc(4);
    rst = 1'b1;
    brk_p = 1'b0;
    ext_p = 1'b0;
    wait_cyc(10);
    check("busy_post_rst", {31'd0, busy}, 32'd0);
    good_frame(8'h1C);

    wait_cyc(50);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_receptor.md
PS2_RECEPTOR -- requirements
Module: ps2_receptor

Interface
REQ-001 Parameter FILTRO_N, default 8: consecutive equal clk_i samples required before the filtered PS/2 clock changes state.
REQ-002 Parameter TIMEOUT_CYC, default 10000: clk_i cycles without a filtered PS/2 falling edge before an open frame is abandoned (1 ms at 10 MHz).
REQ-003 clk_i  input  1  system clock, 10 MHz; the block shall use only this clock.
REQ-004 rst_i  input  1  reset, synchronous to clk_i and active-low.
REQ-005 ps2_reloj_i  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-006 ps2_data_i  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-007 code_o  output  8  last completed scan code, with prefixes stripped.
REQ-008 valid_o  output  1  one-cycle pulse; code_o, break_o and extended_o are valid on this cycle.
REQ-009 break_o  output  1  code_o was preceded by 0xF0 (key release).
REQ-010 extended_o  output  1  code_o was preceded by 0xE0.
REQ-011 error_o  output  1  one-cycle pulse on a parity, stop-bit or timeout failure.
REQ-012 busy_o  output  1  high while a frame is in progress (state other than IDLE).

Function
REQ-013 Each raw input shall pass through a 2-flop synchronizer.
- The PS/2 clock path shall then pass through the FILTRO_N glitch filter.
- Pulses shorter than FILTRO_N cycles shall be ignored.
REQ-014 A falling edge is filtered clock 1 -> 0, detected in one clk_i cycle. The synchronized data bit shall be sampled on that same cycle.
REQ-015 FSM states are IDLE, DATOS, PARIDAD, PARADA. All transitions shall occur only on falling-edge cycles, except timeout.
- IDLE -> DATOS on a falling edge with data = 0 (start bit). A start bit of 1 shall be ignored and the FSM shall stay in IDLE.
- DATOS shall shift 8 bits, LSB first, using a 3-bit counter. It moves to PARIDAD after the 8th bit.
- PARIDAD shall store the parity bit and then move to PARADA.
- PARADA shall sample the stop bit and then return to IDLE.
REQ-016 A frame is good when data bits plus the parity bit contain an odd number of ones and the stop bit = 1. Any other frame shall produce an error_o pulse and no valid_o pulse.
REQ-017 On a good frame:
- Byte 0xF0 shall set an internal break-pending flag.
- Byte 0xE0 shall set an internal ext-pending flag.
- Neither prefix shall pulse valid_o.
REQ-018 On a good frame with any other byte:
- code_o <= byte; break_o <= break-pending; extended_o <= ext-pending; valid_o = 1.
- All three take effect on the cycle after the stop-bit falling edge.
- Both pending flags shall clear on that same cycle.
REQ-019 code_o, break_o and extended_o shall hold their values until the next valid_o pulse.
REQ-020 A timeout counter shall reset on every falling edge and count only while the FSM is not in IDLE. When it reaches TIMEOUT_CYC, the FSM shall go to IDLE and error_o shall pulse.
REQ-021 Any error shall clear both pending flags and the partial shift register.
REQ-022 Latency from the raw stop-bit falling edge to valid_o shall be 2 (synchronizer) + FILTRO_N + 1 clk_i cycles, +/-1.
REQ-023 valid_o and error_o shall never be high on the same cycle.

Reset
REQ-024 While rst_i = 0 at a clk_i edge:
- FSM = IDLE; bit counter = 0; timeout counter = 0; shift register = 0x00.
- Pending flags = 0; synchronizer and filter state = 1 (PS/2 lines idle high).
- code_o = 0x00; valid_o = 0; break_o = 0; extended_o = 0; error_o = 0; busy_o = 0.
REQ-025 A reset asserted mid-frame shall discard the frame with no valid_o or error_o pulse. After reset releases, the next start bit shall begin a fresh frame.

Verification
REQ-026 Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one valid_o pulse with code_o = 0x1C, break_o = 0, extended_o = 0, error_o silent.
REQ-027 Frames F0, 1C -> no valid_o after F0; one valid_o with code_o = 0x1C, break_o = 1, extended_o = 0. A following 0x1C frame then gives break_o = 0.
REQ-028 Frames E0, F0, 75 -> exactly one valid_o, with code_o = 0x75, break_o = 1, extended_o = 1.
REQ-029 Frame 0x1C with parity bit = 1, then frame 0x1C with stop bit = 0 -> two error_o pulses, no valid_o, and code_o unchanged.
REQ-030 Timeout and glitch cases:
- 5 bits of a frame, then PS/2 clock held high for 10000 cycles -> one error_o pulse, busy_o falls, and a following good 0x1C frame is received.
- A 3-cycle low glitch on ps2_reloj_i in IDLE is ignored.
REQ-031 rst_i = 0 pulsed after bit 4 of an F0 frame, then frame 0x1C -> no pulses during the aborted frame, then valid_o with code_o = 0x1C and break_o = 0.
